// File: rtl/stability_pkg.sv
// stability_pkg: classifier state encoding and LED colour commands
package stability_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STABLE = 2'd1,
      ST_WARN   = 2'd2,
      ST_CRIT   = 2'd3
   } state_t;
   localparam logic [2:0] COL_BLUE   = 3'b001;
   localparam logic [2:0] COL_GREEN  = 3'b010;
   localparam logic [2:0] COL_YELLOW = 3'b110;
   localparam logic [2:0] COL_RED    = 3'b100;
   function automatic logic [2:0] color_of(input state_t s);
      return s == ST_CRIT ? COL_RED : s == ST_WARN ? COL_YELLOW : s == ST_STABLE ? COL_GREEN : COL_BLUE;
   endfunction
endpackage

// File: rtl/stability_classifier_if.sv
// stability_classifier_if: error-sample/event inputs and LED driver command outputs
interface stability_classifier_if;
   logic       sample_valid;
   logic [7:0] error_mag;
   logic       event_pulse;
   logic [2:0] color_sel;
   logic       blink_en;
   logic [1:0] level;
   logic       level_chg;
   modport master (output sample_valid, error_mag, event_pulse, input color_sel, blink_en, level, level_chg);
   modport slave (input sample_valid, error_mag, event_pulse, output color_sel, blink_en, level, level_chg);
endinterface

// File: rtl/event_hold_timer.sv
// event_hold_timer: reloadable down-counter, active while nonzero
module event_hold_timer #(
   parameter int EVENT_HOLD = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic active
);
   localparam int HW = $clog2(EVENT_HOLD) + 1;
   localparam logic [HW-1:0] HOLD = HW'(EVENT_HOLD);
   logic [HW-1:0] hold_cnt;
   always_ff @(posedge clk)
      hold_cnt <= rst ? '0 : load ? HOLD : hold_cnt != '0 ? hold_cnt - 1'b1 : '0;
   always_comb active = hold_cnt != '0;
endmodule

// File: rtl/stability_classifier.sv
// stability_classifier: hysteretic error-level FSM producing LED colour/blink commands
module stability_classifier import stability_pkg::*; #(
   parameter int WARN_HI      = 64,
   parameter int WARN_LO      = 48,
   parameter int CRIT_HI      = 160,
   parameter int CRIT_LO      = 128,
   parameter int ESC_CNT      = 4,
   parameter int DESC_CNT     = 8,
   parameter int EVENT_HOLD   = 50_000_000,
   parameter int IDLE_TIMEOUT = 100_000_000
) (
   input logic clk,
   input logic rst,
   stability_classifier_if.slave bus
);
   if (!(WARN_LO <= WARN_HI && WARN_HI <= CRIT_LO && CRIT_LO <= CRIT_HI && CRIT_HI <= 255 &&
         ESC_CNT >= 1 && DESC_CNT >= 1)) begin : g_bad_params
      $error("stability_classifier: thresholds must be ordered and counts >= 1");
   end
   localparam int UW = $clog2(ESC_CNT) + 1;
   localparam int DW = $clog2(DESC_CNT) + 1;
   localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
   localparam logic [7:0] T_WHI = 8'(WARN_HI);
   localparam logic [7:0] T_WLO = 8'(WARN_LO);
   localparam logic [7:0] T_CHI = 8'(CRIT_HI);
   localparam logic [7:0] T_CLO = 8'(CRIT_LO);
   localparam logic [UW-1:0] ESC  = UW'(ESC_CNT);
   localparam logic [DW-1:0] DESC = DW'(DESC_CNT);
   localparam logic [IW-1:0] IT   = IW'(IDLE_TIMEOUT);
   state_t state, state_n;
   logic [UW-1:0] up_cnt, up_n, up_inc;
   logic [DW-1:0] dn_cnt, dn_n, dn_inc;
   logic [IW-1:0] idle_cnt, idle_n;
   logic ge_warn, ge_crit, lt_warn, lt_crit, hold_active;
   event_hold_timer #(.EVENT_HOLD(EVENT_HOLD)) u_hold (
      .clk    (clk),
      .rst    (rst),
      .load   (bus.event_pulse),
      .active (hold_active)
   );
   always_comb begin
      ge_warn = bus.error_mag >= T_WHI;
      ge_crit = bus.error_mag >= T_CHI;
      lt_warn = bus.error_mag < T_WLO;
      lt_crit = bus.error_mag < T_CLO;
      up_inc = &up_cnt ? up_cnt : up_cnt + 1'b1;
      dn_inc = &dn_cnt ? dn_cnt : dn_cnt + 1'b1;
      up_n = up_cnt;
      dn_n = dn_cnt;
      state_n = state;
      idle_n = (state == ST_IDLE || bus.sample_valid) ? '0 : &idle_cnt ? idle_cnt : idle_cnt + 1'b1;
      if (bus.sample_valid) begin
         case (state)
            ST_IDLE:   state_n = ge_crit ? ST_CRIT : ge_warn ? ST_WARN : ST_STABLE;
            ST_STABLE: up_n = ge_warn ? up_inc : '0;
            ST_WARN: begin
               up_n = ge_crit ? up_inc : '0;
               dn_n = lt_warn ? dn_inc : '0;
            end
            default:   dn_n = lt_crit ? dn_inc : '0;
         endcase
         if (state == ST_STABLE && up_n == ESC) state_n = ST_WARN;
         if (state == ST_WARN && up_n == ESC) state_n = ST_CRIT;
         if (state == ST_WARN && dn_n == DESC) state_n = ST_STABLE;
         if (state == ST_CRIT && dn_n == DESC) state_n = ST_WARN;
      end else if (state != ST_IDLE && idle_n == IT) begin
         state_n = ST_IDLE;
      end
      if (state_n != state) begin
         up_n = '0;
         dn_n = '0;
         idle_n = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         up_cnt        <= '0;
         dn_cnt        <= '0;
         idle_cnt      <= '0;
         bus.color_sel <= COL_BLUE;
         bus.blink_en  <= 1'b0;
         bus.level     <= 2'd0;
         bus.level_chg <= 1'b0;
      end else begin
         state         <= state_n;
         up_cnt        <= up_n;
         dn_cnt        <= dn_n;
         idle_cnt      <= idle_n;
         bus.color_sel <= color_of(state);
         bus.blink_en  <= hold_active || state == ST_CRIT;
         bus.level     <= state;
         bus.level_chg <= bus.level != state;
      end
   end
endmodule

// File: tb/tb_stability_classifier.sv
// tb_stability_classifier: table-driven and directed checks of the stability classifier
module tb_stability_classifier;
   import stability_pkg::*;
   typedef struct {
      logic       sv;
      logic [7:0] err;
      logic [2:0] col;
      logic       blink;
      logic [1:0] lvl;
      logic       chg;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   vec_t vecs[$];
   stability_classifier_if bus();
   stability_classifier #(
      .ESC_CNT(4), .DESC_CNT(8), .EVENT_HOLD(10), .IDLE_TIMEOUT(20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic cyc(input logic sv, input logic [7:0] e, input logic ev);
      @(negedge clk);
      bus.sample_valid = sv;
      bus.error_mag = e;
      bus.event_pulse = ev;
      @(posedge clk);
      #1;
   endtask
   task automatic reset_edge(input string tag);
      @(negedge clk);
      rst = 1'b1;
      bus.sample_valid = 1'b0;
      bus.event_pulse = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " color"}, int'(bus.color_sel), int'(COL_BLUE));
      chk({tag, " blink"}, int'(bus.blink_en), 0);
      chk({tag, " level"}, int'(bus.level), 0);
      chk({tag, " chg"}, int'(bus.level_chg), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask
   function automatic void add(input logic sv, input logic [7:0] err, input logic [2:0] col,
                               input logic blink, input logic [1:0] lvl, input logic chg);
      vec_t v;
      v.sv = sv; v.err = err; v.col = col; v.blink = blink; v.lvl = lvl; v.chg = chg;
      vecs.push_back(v);
   endfunction
   initial begin
      bus.sample_valid = 1'b0;
      bus.error_mag = 8'd0;
      bus.event_pulse = 1'b0;
      // each row: stimulus at an edge, outputs expected right after that edge
      add(1, 30, COL_BLUE, 0, 0, 0);
      add(0, 0, COL_GREEN, 0, 1, 1);
      for (int i = 0; i < 3; i++) add(1, 70, COL_GREEN, 0, 1, 0);
      add(1, 10, COL_GREEN, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(1, 70, COL_GREEN, 0, 1, 0);
      add(0, 0, COL_YELLOW, 0, 2, 1);
      for (int i = 0; i < 4; i++) add(1, 200, COL_YELLOW, 0, 2, 0);
      add(0, 0, COL_RED, 1, 3, 1);
      for (int i = 0; i < 3; i++) add(1, 100, COL_RED, 1, 3, 0);
      add(1, 130, COL_RED, 1, 3, 0);
      for (int i = 0; i < 8; i++) add(1, 100, COL_RED, 1, 3, 0);
      add(0, 0, COL_YELLOW, 0, 2, 1);
      for (int i = 0; i < 19; i++) add(0, 0, COL_YELLOW, 0, 2, 0);
      add(0, 0, COL_BLUE, 0, 0, 1);
      add(0, 0, COL_BLUE, 0, 0, 0);
      reset_edge("reset");
      foreach (vecs[i]) begin
         cyc(vecs[i].sv, vecs[i].err, 1'b0);
         chk($sformatf("row%0d color", i), int'(bus.color_sel), int'(vecs[i].col));
         chk($sformatf("row%0d blink", i), int'(bus.blink_en), int'(vecs[i].blink));
         chk($sformatf("row%0d level", i), int'(bus.level), int'(vecs[i].lvl));
         chk($sformatf("row%0d chg", i), int'(bus.level_chg), int'(vecs[i].chg));
      end
      // sample landing on the timeout cycle keeps WARN and restarts the timer
      cyc(1, 100, 0);
      for (int i = 1; i < 20; i++) cyc(0, 0, 0);
      cyc(1, 50, 0);
      cyc(0, 0, 0);
      chk("late sample level", int'(bus.level), 2);
      chk("late sample color", int'(bus.color_sel), int'(COL_YELLOW));
      for (int i = 22; i < 41; i++) cyc(0, 0, 0);
      chk("timer restart still warn", int'(bus.level), 2);
      cyc(0, 0, 0);
      chk("timeout level", int'(bus.level), 0);
      chk("timeout chg", int'(bus.level_chg), 1);
      // reloaded blink hold in STABLE
      for (int c = 0; c <= 16; c++) begin
         cyc(1, 30, c == 0 || c == 5);
         chk($sformatf("hold c%0d blink", c), int'(bus.blink_en), int'(c >= 1 && c <= 15));
      end
      chk("hold level stable", int'(bus.level), 1);
      // IDLE jumps straight to CRIT, then reset aborts hold
      reset_edge("reset2");
      cyc(1, 200, 0);
      cyc(0, 0, 0);
      chk("direct crit level", int'(bus.level), 3);
      chk("direct crit color", int'(bus.color_sel), int'(COL_RED));
      chk("direct crit blink", int'(bus.blink_en), 1);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      reset_edge("mid-hold reset");
      cyc(0, 0, 0);
      chk("post reset blink", int'(bus.blink_en), 0);
      chk("post reset color", int'(bus.color_sel), int'(COL_BLUE));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
